// File: rtl/gpu_pkg.sv
// Shared encodings for the core scheduler and the per-thread load/store unit.
//   core_state_t : scheduler stage driven by the core, sampled by the LSU
//   lsu_state_t  : LSU progress, polled by the scheduler to leave WAIT
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Consumer port between one LSU and the memory controller.
//   master : LSU side, drives the request valids, addresses and write data
//   slave  : controller side, drives the ready acknowledges and read data
interface lsu_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/lsu.sv
// Per-thread load/store unit. Turns a decoded LDR/STR into one valid/ready
// transaction on the memory controller consumer port and captures load data.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   enable                     : thread active in this block
//   core_state                 : scheduler stage (gpu_pkg::core_state_t)
//   decoded_mem_read_enable    : instruction is LDR (wins over STR)
//   decoded_mem_write_enable   : instruction is STR
//   rs, rt                     : address operand (low ADDR_BITS used), store data
//   mem                        : controller consumer port (lsu_if master)
//   lsu_state                  : IDLE/REQUESTING/WAITING/DONE
//   lsu_out                    : last loaded value
//
// state      | meaning
// IDLE       | no transaction; waits for the REQUEST stage with an LDR/STR
// REQUESTING | operation latched; valid/address/data registered next edge
// WAITING    | valid high, payload held until the matching ready
// DONE       | handshake finished; ready ignored until the UPDATE stage
module lsu
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  lsu_if.master                mem,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out
);

  lsu_state_t state;
  logic       is_read;

  // Upper address-operand bits are intentionally discarded (no bounds check).
  logic unused_rs_high;
  assign unused_rs_high = &{1'b0, rs[DATA_BITS-1:ADDR_BITS]};

  assign lsu_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= LSU_IDLE;
      is_read               <= 1'b0;
      mem.mem_read_valid    <= 1'b0;
      mem.mem_read_address  <= '0;
      mem.mem_write_valid   <= 1'b0;
      mem.mem_write_address <= '0;
      mem.mem_write_data    <= '0;
      lsu_out               <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          // enable only gates the start; an issued transaction always completes
          if (enable && (core_state == CORE_REQUEST) &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            is_read <= decoded_mem_read_enable;
            state   <= LSU_REQUESTING;
          end
        end
        LSU_REQUESTING: begin
          if (is_read) begin
            mem.mem_read_valid   <= 1'b1;
            mem.mem_read_address <= rs[ADDR_BITS-1:0];
          end else begin
            mem.mem_write_valid   <= 1'b1;
            mem.mem_write_address <= rs[ADDR_BITS-1:0];
            mem.mem_write_data    <= rt;
          end
          state <= LSU_WAITING;
        end
        LSU_WAITING: begin
          if (is_read && mem.mem_read_ready) begin
            mem.mem_read_valid <= 1'b0;
            lsu_out            <= mem.mem_read_data;
            state              <= LSU_DONE;
          end else if (!is_read && mem.mem_write_ready) begin
            mem.mem_write_valid <= 1'b0;
            state               <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          // controller may still hold ready here until it sees valid low
          if (core_state == CORE_UPDATE) begin
            state <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: scripted scheduler stages, a memory responder
// with programmable ready latency, and a request scoreboard.
module tb_lsu;
  import gpu_pkg::*;

  localparam int AB = 8;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    core_state;
  logic          rd_en;
  logic          wr_en;
  logic [DB-1:0] rs;
  logic [DB-1:0] rt;
  logic [1:0]    lsu_state;
  logic [DB-1:0] lsu_out;

  lsu_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mem_bus ();

  lsu #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem                      (mem_bus),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
  } req_t;

  req_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            resp_delay = 0;
  logic [DB-1:0] rd_data = '0;
  logic [DB-1:0] exp_out = '0;

  // Memory responder: sees a new request, pops the scoreboard, raises the
  // matching ready after resp_delay cycles, drops it once valid is gone.
  initial begin : responder
    int   cnt;
    logic busy;
    logic cur_wr;
    req_t got;
    req_t e;
    busy = 1'b0;
    cnt = 0;
    cur_wr = 1'b0;
    mem_bus.mem_read_ready  = 1'b0;
    mem_bus.mem_write_ready = 1'b0;
    mem_bus.mem_read_data   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0;
        mem_bus.mem_read_ready  = 1'b0;
        mem_bus.mem_write_ready = 1'b0;
      end else begin
        checks++;
        if (mem_bus.mem_read_valid && mem_bus.mem_write_valid) begin
          failures++;
          $display("FAIL dual_valid: read and write valid both high at %0t", $time);
        end
        if (!busy && (mem_bus.mem_read_valid || mem_bus.mem_write_valid)) begin
          busy   = 1'b1;
          cnt    = resp_delay;
          cur_wr = mem_bus.mem_write_valid;
          got.wr   = cur_wr;
          got.addr = cur_wr ? mem_bus.mem_write_address : mem_bus.mem_read_address;
          got.data = cur_wr ? mem_bus.mem_write_data : '0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got request wr=%0d addr=%h data=%h, required none",
                     got.wr, got.addr, got.data);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              failures++;
              $display("FAIL sb_request: got wr=%0d addr=%h data=%h, required wr=%0d addr=%h data=%h",
                       got.wr, got.addr, got.data, e.wr, e.addr, e.data);
            end
          end
        end
        if (busy && !(mem_bus.mem_read_ready || mem_bus.mem_write_ready)) begin
          if (cnt == 0) begin
            if (cur_wr) mem_bus.mem_write_ready = 1'b1;
            else begin
              mem_bus.mem_read_ready = 1'b1;
              mem_bus.mem_read_data  = rd_data;
            end
          end else begin
            cnt--;
          end
        end else if (busy && !(mem_bus.mem_read_valid || mem_bus.mem_write_valid)) begin
          mem_bus.mem_read_ready  = 1'b0;
          mem_bus.mem_write_ready = 1'b0;
          busy = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    core_state = CORE_IDLE;
    rd_en = 1'b0;
    wr_en = 1'b0;
    rs = '0;
    rt = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_out = '0;
  endtask

  task automatic test_reset();
    checks++;
    if ({mem_bus.mem_read_valid, mem_bus.mem_read_address, mem_bus.mem_write_valid,
         mem_bus.mem_write_address, mem_bus.mem_write_data, lsu_out, lsu_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rv=%b ra=%h wv=%b wa=%h wd=%h out=%h st=%0d, required all 0",
               mem_bus.mem_read_valid, mem_bus.mem_read_address, mem_bus.mem_write_valid,
               mem_bus.mem_write_address, mem_bus.mem_write_data, lsu_out, lsu_state);
    end
  endtask

  // One full LDR/STR through the scheduler stages, with latency and stability checks.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [DB-1:0] a, input logic [DB-1:0] d,
                         input int delay, input logic [DB-1:0] mem_val, input logic drop_en);
    req_t          r;
    logic          exp_wr;
    logic          stable_ok;
    logic [AB-1:0] snap_a;
    logic [DB-1:0] snap_d;
    int            n;
    exp_wr = !rd;
    r.wr   = exp_wr;
    r.addr = a[AB-1:0];
    r.data = exp_wr ? d : '0;
    exp_q.push_back(r);
    if (rd) exp_out = mem_val;

    enable = 1'b1; rd_en = rd; wr_en = wr; rs = a; rt = d;
    resp_delay = delay; rd_data = mem_val;
    core_state = CORE_REQUEST;
    @(negedge clk);
    checks++;
    if (lsu_state !== LSU_REQUESTING || mem_bus.mem_read_valid || mem_bus.mem_write_valid) begin
      failures++;
      $display("FAIL %s_requesting: st=%0d rv=%b wv=%b, required st=1 rv=0 wv=0",
               name, lsu_state, mem_bus.mem_read_valid, mem_bus.mem_write_valid);
    end
    core_state = CORE_WAIT;
    @(negedge clk);
    checks++;
    if (lsu_state !== LSU_WAITING || mem_bus.mem_read_valid !== !exp_wr ||
        mem_bus.mem_write_valid !== exp_wr) begin
      failures++;
      $display("FAIL %s_issue: st=%0d rv=%b wv=%b, required st=2 rv=%b wv=%b",
               name, lsu_state, mem_bus.mem_read_valid, mem_bus.mem_write_valid, !exp_wr, exp_wr);
    end
    snap_a = exp_wr ? mem_bus.mem_write_address : mem_bus.mem_read_address;
    snap_d = mem_bus.mem_write_data;
    if (drop_en) enable = 1'b0;

    stable_ok = 1'b1;
    n = 0;
    while (n < 500 && lsu_state !== LSU_DONE) begin
      if (lsu_state !== LSU_WAITING) stable_ok = 1'b0;
      if (exp_wr) begin
        if (!mem_bus.mem_write_valid || mem_bus.mem_read_valid ||
            mem_bus.mem_write_address !== snap_a || mem_bus.mem_write_data !== snap_d)
          stable_ok = 1'b0;
      end else begin
        if (!mem_bus.mem_read_valid || mem_bus.mem_write_valid ||
            mem_bus.mem_read_address !== snap_a)
          stable_ok = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (lsu_state !== LSU_DONE) begin
      failures++;
      $display("FAIL %s_timeout: st=%0d after %0d cycles, required DONE", name, lsu_state, n);
    end
    checks++;
    if (!stable_ok || n != delay + 1) begin
      failures++;
      $display("FAIL %s_wait: stable=%b cycles=%0d, required stable=1 cycles=%0d",
               name, stable_ok, n, delay + 1);
    end
    checks++;
    if (mem_bus.mem_read_valid || mem_bus.mem_write_valid || lsu_out !== exp_out) begin
      failures++;
      $display("FAIL %s_done: rv=%b wv=%b out=%h, required rv=0 wv=0 out=%h",
               name, mem_bus.mem_read_valid, mem_bus.mem_write_valid, lsu_out, exp_out);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_sb_pending: %0d entries left, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if (lsu_state !== LSU_DONE) begin
      failures++;
      $display("FAIL %s_done_hold: st=%0d, required 3", name, lsu_state);
    end
    core_state = CORE_UPDATE;
    @(negedge clk);
    checks++;
    if (lsu_state !== LSU_IDLE || lsu_out !== exp_out) begin
      failures++;
      $display("FAIL %s_update: st=%0d out=%h, required st=0 out=%h", name, lsu_state, lsu_out, exp_out);
    end
    core_state = CORE_IDLE;
    enable = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    run_txn("load", 1'b1, 1'b0, 16'h0012, 16'h0000, 2, 16'hBEEF, 1'b0);
    checks++;
    if (mem_bus.mem_read_address !== 8'h12) begin
      failures++;
      $display("FAIL load_addr: got %h, required 12", mem_bus.mem_read_address);
    end
  endtask

  task automatic test_store();
    run_txn("store", 1'b0, 1'b1, 16'h0105, 16'h00A5, 1, 16'h5555, 1'b0);
    checks++;
    if (mem_bus.mem_write_address !== 8'h05 || mem_bus.mem_write_data !== 16'h00A5) begin
      failures++;
      $display("FAIL store_payload: addr=%h data=%h, required addr=05 data=00a5",
               mem_bus.mem_write_address, mem_bus.mem_write_data);
    end
  endtask

  task automatic test_stall();
    run_txn("stall_wr", 1'b0, 1'b1, 16'h00C3, 16'h1234, 50, 16'h0000, 1'b0);
    run_txn("stall_rd", 1'b1, 1'b0, 16'hFF7E, 16'h0000, 50, 16'h4321, 1'b0);
  endtask

  task automatic test_reset_waiting();
    req_t r;
    logic ok;
    r.wr = 1'b0; r.addr = 8'h33; r.data = '0;
    exp_q.push_back(r);
    resp_delay = 1000;
    rd_en = 1'b1; rs = 16'h0033; core_state = CORE_REQUEST;
    @(negedge clk);
    core_state = CORE_WAIT;
    @(negedge clk);
    checks++;
    if (!mem_bus.mem_read_valid || lsu_state !== LSU_WAITING) begin
      failures++;
      $display("FAIL rstw_pre: rv=%b st=%0d, required rv=1 st=2", mem_bus.mem_read_valid, lsu_state);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_out = '0;
    checks++;
    if ({mem_bus.mem_read_valid, mem_bus.mem_read_address, mem_bus.mem_write_valid,
         mem_bus.mem_write_address, mem_bus.mem_write_data, lsu_out, lsu_state} !== '0) begin
      failures++;
      $display("FAIL rstw_outputs: rv=%b ra=%h wv=%b out=%h st=%0d, required all 0",
               mem_bus.mem_read_valid, mem_bus.mem_read_address, mem_bus.mem_write_valid,
               lsu_out, lsu_state);
    end
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (lsu_state !== LSU_IDLE || mem_bus.mem_read_valid || mem_bus.mem_write_valid) ok = 1'b0;
    end
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rstw_quiet: ok=%b pending=%0d, required ok=1 pending=0", ok, exp_q.size());
      exp_q.delete();
    end
    core_state = CORE_IDLE; rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_disabled();
    logic ok;
    ok = 1'b1;
    enable = 1'b0; rd_en = 1'b1; wr_en = 1'b0; rs = 16'h0044;
    core_state = CORE_REQUEST;
    repeat (4) begin
      @(negedge clk);
      if (lsu_state !== LSU_IDLE || mem_bus.mem_read_valid || mem_bus.mem_write_valid) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL disabled_enable: lsu left IDLE or issued with enable=0, required IDLE");
    end
    ok = 1'b1;
    enable = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (lsu_state !== LSU_IDLE || mem_bus.mem_read_valid || mem_bus.mem_write_valid) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL disabled_nodecode: lsu left IDLE or issued with no decode, required IDLE");
    end
    core_state = CORE_IDLE;
    @(negedge clk);
  endtask

  task automatic test_both_enables();
    run_txn("both", 1'b1, 1'b1, 16'h0077, 16'hDEAD, 3, 16'hCAFE, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_rd", 1'b1, 1'b0, 16'h0101, 16'h0000, 0, 16'h0F0F, 1'b1);
    run_txn("b2b_wr", 1'b0, 1'b1, 16'h02FE, 16'hA5A5, 0, 16'h0000, 1'b0);
    run_txn("b2b_rd2", 1'b1, 1'b0, 16'h0080, 16'h0000, 4, 16'h8001, 1'b0);
  endtask

  initial begin
    do_reset();
    test_reset();
    test_load();
    test_store();
    test_stall();
    test_reset_waiting();
    test_disabled();
    test_both_enables();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
